serial_receiver: RTL and testbench

- Receive side of the serial link whose transmit side is driven by the tx_clk/edge-pulse clock generator.
- Oversamples an external serial clock, data and active-low select in the single system clock domain.
- Detects serial-clock rising edges and shifts in fixed-width words.
- Presents each completed word on a valid/ready output buffer, with overrun, framing and timeout error pulses.

---
 rtl/serial_pkg.sv | 13 +
 rtl/edge_detector.sv | 27 ++
 rtl/input_synchronizer.sv | 25 ++
 rtl/serial_receiver.sv | 189 ++++++++++++++++++
 tb/tb_serial_receiver.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Definitions shared by the transmit and receive sides of the serial link.
package serial_pkg;

  // Word width used by both ends of the link unless overridden.
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/edge_detector.sv
// Registered rising-edge detector on an already-synchronized signal.
module edge_detector #(
  parameter logic INITIAL_DATA = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_data,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  // Remember the previous level and register a one-cycle pulse on a 0->1 step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= INITIAL_DATA;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_data;
      r_rise <= i_data & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer bringing one asynchronous input into the clk domain.
module input_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw input through the flop chain; the last stage is the safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Oversampling serial receiver: synchronizes sclk/sdata/cs_n, shifts in words
// on sclk rising edges and hands them out through a one-word valid/ready buffer.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          MSB_FIRST      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk_in,
  input  logic                  sdata_in,
  input  logic                  cs_n_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  frame_error,
  output logic                  timeout,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES - 1);
  // The timeout fires on the edge where the watchdog would step onto its last value.
  localparam logic [WD_W-1:0]  WD_EXPIRE = WD_W'(TIMEOUT_CYCLES - 2);

  logic w_sclk;
  logic w_sdata;
  logic w_cs_n;
  logic w_rise;

  rx_state_t r_state;
  rx_state_t w_next_state;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [WD_W-1:0]       r_wd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_frame_error;
  logic                  r_timeout;

  logic w_clear;
  logic w_shift_en;
  logic w_word_done;
  logic w_frame_err;
  logic w_timeout;

  input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(sclk_in), .o_sync(w_sclk)
  );

  input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_sdata (
    .clk(clk), .rst_n(rst_n), .i_async(sdata_in), .o_sync(w_sdata)
  );

  input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .i_async(cs_n_in), .o_sync(w_cs_n)
  );

  edge_detector #(.INITIAL_DATA(1'b0)) u_sclk_rise (
    .clk(clk), .rst_n(rst_n), .i_data(w_sclk), .o_rise(w_rise)
  );

  // Next shift-register value with the current synchronized data bit inserted.
  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST) begin
      w_shift_next = {r_shift[DATA_WIDTH-2:0], w_sdata};
    end else begin
      w_shift_next = {w_sdata, r_shift[DATA_WIDTH-1:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode; cs_n release outranks a same-cycle rise.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift_en   = 1'b0;
    w_word_done  = 1'b0;
    w_frame_err  = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_cs_n) begin
          w_next_state = ACTIVE;
          w_clear      = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_n) begin
          w_next_state = IDLE;
          w_clear      = 1'b1;
          w_frame_err  = (r_cnt != '0);
        end else if (w_rise) begin
          w_shift_en  = 1'b1;
          w_word_done = (r_cnt == CNT_LAST);
        end else if ((r_cnt != '0) && (r_wd == WD_EXPIRE)) begin
          w_next_state = ABORT;
          w_clear      = 1'b1;
          w_timeout    = 1'b1;
        end
      end
      ABORT: begin
        if (w_cs_n) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and saturating mid-word watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_wd    <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
      r_wd  <= '0;
    end else if (w_shift_en) begin
      r_shift <= w_shift_next;
      r_cnt   <= w_word_done ? '0 : r_cnt + 1'b1;
      r_wd    <= '0;
    end else if ((r_state == ACTIVE) && (r_cnt != '0) && (r_wd != WD_MAX)) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // One-word output buffer: a completed word loads if the slot is free or being
  // drained this cycle, otherwise it is dropped and flagged as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_word_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= w_shift_next;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Registered single-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_error <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_frame_error <= w_frame_err;
      r_timeout     <= w_timeout;
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign overrun     = r_overrun;
  assign frame_error = r_frame_error;
  assign timeout     = r_timeout;
  assign busy        = (r_state == ACTIVE);

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: scenario tasks drive the serial pins,
// push expected words into a scoreboard and compare against accepted words.
module tb_serial_receiver;

  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned TO = 32;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          sclk_in  = 1'b0;
  logic          sdata_in = 1'b0;
  logic          cs_n_in  = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          overrun;
  logic          frame_error;
  logic          timeout;
  logic          busy;

  serial_receiver #(
    .DATA_WIDTH(DW),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYCLES(TO),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk_in(sclk_in),
    .sdata_in(sdata_in),
    .cs_n_in(cs_n_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .overrun(overrun),
    .frame_error(frame_error),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records accepted words and counts pulses, away from the edge.
  logic [DW-1:0] obs_mem [0:63];
  int            obs_cyc [0:63];
  int            obs_cnt = 0;
  int            vcycles = 0;
  int            ov_cnt  = 0;
  int            fe_cnt  = 0;
  int            to_cnt  = 0;
  int            to_cyc  = 0;

  always @(negedge clk) begin
    if (rx_valid) vcycles <= vcycles + 1;
    if (rx_valid && rx_ready && obs_cnt < 64) begin
      obs_mem[obs_cnt] <= rx_data;
      obs_cyc[obs_cnt] <= cyc;
      obs_cnt          <= obs_cnt + 1;
    end
    if (overrun)     ov_cnt <= ov_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (timeout) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  int            n_cmp = 0;
  int            n_bad = 0;
  int            rd_idx = 0;
  int            last_rise_cyc = 0;
  logic [DW-1:0] exp_q [$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive nbits MSB-first; data changes while sclk is low, sclk period 16 clk.
  task automatic send_bits(input logic [DW-1:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sdata_in = d[DW-1-i];
      sclk_in  = 1'b0;
      tick(8);
      sclk_in       = 1'b1;
      last_rise_cyc = cyc;
      tick(8);
    end
  endtask

  task automatic frame_start();
    sclk_in = 1'b0;
    cs_n_in = 1'b0;
    tick(6);
  endtask

  task automatic frame_end();
    cs_n_in = 1'b1;
    tick(6);
  endtask

  // Pop every expected word and compare with the next accepted word.
  task automatic check_words(input string name);
    logic [DW-1:0] e;
    int w;
    while (exp_q.size() > 0) begin
      w = 0;
      while (obs_cnt <= rd_idx && w < 400) begin
        tick(1);
        w++;
      end
      n_cmp++;
      if (obs_cnt <= rd_idx) begin
        $display("FAIL %s word: no word accepted, expected %h", name, exp_q[0]);
        n_bad++;
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[rd_idx] !== e) begin
          $display("FAIL %s word: got %h expected %h", name, obs_mem[rd_idx], e);
          n_bad++;
        end
        rd_idx++;
      end
    end
    n_cmp++;
    if (obs_cnt != rd_idx) begin
      $display("FAIL %s extra words: got %0d accepted expected %0d", name, obs_cnt, rd_idx);
      n_bad++;
    end
    rd_idx = obs_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_cmp++; if (rx_valid !== 1'b0)    begin $display("FAIL reset rx_valid: got %b expected 0", rx_valid); n_bad++; end
    n_cmp++; if (rx_data !== '0)       begin $display("FAIL reset rx_data: got %h expected 00", rx_data); n_bad++; end
    n_cmp++; if (busy !== 1'b0)        begin $display("FAIL reset busy: got %b expected 0", busy); n_bad++; end
    n_cmp++; if (overrun !== 1'b0)     begin $display("FAIL reset overrun: got %b expected 0", overrun); n_bad++; end
    n_cmp++; if (frame_error !== 1'b0) begin $display("FAIL reset frame_error: got %b expected 0", frame_error); n_bad++; end
    n_cmp++; if (timeout !== 1'b0)     begin $display("FAIL reset timeout: got %b expected 0", timeout); n_bad++; end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_directed_byte();
    int b_idx, b_v, b_ov, b_fe, b_to, lat;
    rx_ready = 1'b1;
    b_idx = obs_cnt; b_v = vcycles; b_ov = ov_cnt; b_fe = fe_cnt; b_to = to_cnt;
    frame_start();
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    n_cmp++;
    if (obs_cnt <= b_idx) begin
      $display("FAIL directed latency: no word seen, expected at +%0d", SS + 2);
      n_bad++;
    end else begin
      lat = obs_cyc[b_idx] - last_rise_cyc;
      if (lat != SS + 2) begin
        $display("FAIL directed latency: got %0d expected %0d", lat, SS + 2);
        n_bad++;
      end
    end
    n_cmp++; if (vcycles - b_v != 1) begin $display("FAIL directed valid width: got %0d expected 1", vcycles - b_v); n_bad++; end
    frame_end();
    n_cmp++; if (ov_cnt != b_ov) begin $display("FAIL directed overrun: got %0d expected 0", ov_cnt - b_ov); n_bad++; end
    n_cmp++; if (fe_cnt != b_fe) begin $display("FAIL directed frame_error: got %0d expected 0", fe_cnt - b_fe); n_bad++; end
    n_cmp++; if (to_cnt != b_to) begin $display("FAIL directed timeout: got %0d expected 0", to_cnt - b_to); n_bad++; end
    check_words("directed");
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int b_ov;
    rx_ready = 1'b0;
    b_ov = ov_cnt;
    frame_start();
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    n_cmp++; if (rx_valid !== 1'b1)   begin $display("FAIL b2b rx_valid: got %b expected 1", rx_valid); n_bad++; end
    n_cmp++; if (rx_data !== 8'h3C)   begin $display("FAIL b2b rx_data held: got %h expected 3c", rx_data); n_bad++; end
    n_cmp++; if (ov_cnt - b_ov != 1)  begin $display("FAIL b2b overrun count: got %0d expected 1", ov_cnt - b_ov); n_bad++; end
    frame_end();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
    n_cmp++; if (rx_valid !== 1'b0)   begin $display("FAIL b2b drained rx_valid: got %b expected 0", rx_valid); n_bad++; end
    check_words("b2b");
  endtask

  task automatic test_accept_same_cycle();
    int b_ov;
    rx_ready = 1'b0;
    b_ov = ov_cnt;
    frame_start();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_bits(8'h11, 8);
    send_bits(8'h22, 7);
    // Final bit of 8'h22 is 0; raise rx_ready in the cycle the word completes.
    sdata_in = 1'b0;
    sclk_in  = 1'b0;
    tick(8);
    sclk_in = 1'b1;
    tick(SS + 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b1)  begin $display("FAIL same-cycle rx_valid: got %b expected 1", rx_valid); n_bad++; end
    n_cmp++; if (rx_data !== 8'h22)  begin $display("FAIL same-cycle rx_data: got %h expected 22", rx_data); n_bad++; end
    n_cmp++; if (ov_cnt != b_ov)     begin $display("FAIL same-cycle overrun: got %0d expected 0", ov_cnt - b_ov); n_bad++; end
    tick(6);
    frame_end();
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    check_words("same-cycle");
  endtask

  task automatic test_frame_error();
    int b_fe, b_v;
    rx_ready = 1'b1;
    b_fe = fe_cnt; b_v = vcycles;
    frame_start();
    send_bits(8'hB7, 5);
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL frame busy mid-word: got %b expected 1", busy); n_bad++; end
    cs_n_in = 1'b1;
    tick(6);
    n_cmp++; if (fe_cnt - b_fe != 1) begin $display("FAIL frame_error count: got %0d expected 1", fe_cnt - b_fe); n_bad++; end
    n_cmp++; if (vcycles != b_v)     begin $display("FAIL frame rx_valid cycles: got %0d expected 0", vcycles - b_v); n_bad++; end
    n_cmp++; if (busy !== 1'b0)      begin $display("FAIL frame busy after: got %b expected 0", busy); n_bad++; end
    frame_start();
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8);
    frame_end();
    n_cmp++; if (fe_cnt - b_fe != 1) begin $display("FAIL frame_error after good word: got %0d expected 1", fe_cnt - b_fe); n_bad++; end
    check_words("frame");
    rx_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int b_to, b_v, b_fe, dt;
    rx_ready = 1'b1;
    b_to = to_cnt; b_fe = fe_cnt;
    frame_start();
    send_bits(8'hE0, 3);
    tick(50);
    n_cmp++; if (to_cnt - b_to != 1) begin $display("FAIL timeout count: got %0d expected 1", to_cnt - b_to); n_bad++; end
    dt = to_cyc - last_rise_cyc;
    n_cmp++; if (dt != SS + 1 + TO)  begin $display("FAIL timeout latency: got %0d expected %0d", dt, SS + 1 + TO); n_bad++; end
    n_cmp++; if (busy !== 1'b0)      begin $display("FAIL timeout busy: got %b expected 0", busy); n_bad++; end
    b_v = vcycles;
    send_bits(8'hFF, 8);
    n_cmp++; if (vcycles != b_v)     begin $display("FAIL abort ignores sclk: got %0d valid cycles expected 0", vcycles - b_v); n_bad++; end
    n_cmp++; if (to_cnt - b_to != 1) begin $display("FAIL abort extra timeout: got %0d expected 1", to_cnt - b_to); n_bad++; end
    frame_end();
    n_cmp++; if (fe_cnt != b_fe)     begin $display("FAIL abort frame_error: got %0d expected 0", fe_cnt - b_fe); n_bad++; end
    frame_start();
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8);
    frame_end();
    check_words("timeout");
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    int b_fe;
    rx_ready = 1'b0;
    frame_start();
    send_bits(8'h77, 8);
    send_bits(8'hF0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_valid !== 1'b0) begin $display("FAIL midreset rx_valid: got %b expected 0", rx_valid); n_bad++; end
    n_cmp++; if (rx_data !== '0)    begin $display("FAIL midreset rx_data: got %h expected 00", rx_data); n_bad++; end
    n_cmp++; if (busy !== 1'b0)     begin $display("FAIL midreset busy: got %b expected 0", busy); n_bad++; end
    cs_n_in = 1'b1;
    sclk_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    b_fe = fe_cnt;
    rx_ready = 1'b1;
    frame_start();
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8);
    frame_end();
    n_cmp++; if (fe_cnt != b_fe) begin $display("FAIL midreset frame_error: got %0d expected 0", fe_cnt - b_fe); n_bad++; end
    check_words("midreset");
    rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed_byte();
    test_back_to_back();
    test_accept_same_cycle();
    test_frame_error();
    test_timeout();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global time limit: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
